envelope_gen: RTL
=================

// Module: envelope_gen
// PURPOSE
//   Amplitude envelope (attack/sustain/release) between the sine generator and the PWM DACs.
//   - Scales the pos/neg half-wave samples by an 8-bit gain that ramps at the sample rate.
//   - Notes start and stop without clicks.
//   - Note events come from the melody sequencer; sample_en is a 1-cycle strobe at fs (8 kHz).
// PARAMETERS
//   N            8   sample width of pos/neg in/out (matches DAC bitwidth)
//   G            8   gain register width; full scale GMAX = 2^G-1
//   ATTACK_STEP  16  gain increment per sample_en in ATTACK
//   RELEASE_STEP 8   gain decrement per sample_en in RELEASE
// PORTS
//   clk        in   1  system clock
//   reset      in   1  asynchronous, active-high reset
//   sample_en  in   1  1-cycle strobe, one per output sample
//   note_on    in   1  1-cycle pulse: start/retrigger note
//   note_off   in   1  1-cycle pulse: release note
//   pos_in     in   N  positive half-wave sample from sine
//   neg_in     in   N  negative half-wave sample from sine
//   pos_out    out  N  scaled positive sample to dac_pos t_on
//   neg_out    out  N  scaled negative sample to dac_neg t_on
//   busy       out  1  1 when state != IDLE
//   state      out  2  IDLE=00 ATTACK=01 SUSTAIN=10 RELEASE=11
// BEHAVIOUR
//   - Reset (async, any time incl. mid-ramp): state=IDLE, gain=0, pos_out=neg_out=0, busy=0.
//   - Note events act on the clk edge where they are asserted; they do not wait for sample_en.
//   - Event rules, all states:
//     - note_on -> ATTACK, from the current gain (no reset to 0 = no click).
//     - note_off in ATTACK/SUSTAIN -> RELEASE.
//     - note_off in IDLE/RELEASE is ignored.
//     - note_on and note_off in the same cycle: note_on wins.
//   - Gain changes only on sample_en, and only on cycles without a note event.
//     On an event cycle the state changes and the gain holds; stepping resumes at the next strobe.
//   - ATTACK:
//     - gain <= min(gain+ATTACK_STEP, GMAX); compute in G+1 bits, saturate, never wrap.
//     - gain reaching GMAX -> SUSTAIN on the same edge.
//   - SUSTAIN: gain holds at GMAX until note_off/note_on.
//   - RELEASE:
//     - gain <= max(gain-RELEASE_STEP, 0); saturate, never underflow.
//     - gain reaching 0 -> IDLE on the same edge.
//   - IDLE: gain=0.
//   - Output datapath, registered, updated only on sample_en edges:
//     - out = (gain==GMAX) ? in : (in*gain)>>G. Product is N+G bits; keep bits [N+G-1:G].
//     - Uses the gain value before that edge's update (1-strobe gain latency).
//     - pos/neg are scaled identically and independently.
//   - Outputs hold between strobes. Latency from input to output is one clk after sample_en.
//   - busy is combinational from the state register.
// TESTING
//   1. Attack: note_on, pos_in=200, 17 strobes.
//      -> gain 16,32..240,255; SUSTAIN after strobe 16; pos_out=200 after strobe 17.
//   2. Release: note_off in SUSTAIN.
//      -> gain 247..7,0 over 32 strobes; IDLE, busy=0; pos_out=0 after next strobe.
//   3. Retrigger: note_on in RELEASE at gain=127.
//      -> state ATTACK, gain=127; next strobe gain=143.
//   4. Simultaneous note_on+note_off in SUSTAIN (with sample_en).
//      -> ATTACK, gain stays 255 on that edge.
//   5. Scaling: gain=128, pos_in=255, neg_in=3 -> pos_out=127, neg_out=1.
//   6. Async reset mid-ATTACK between clk edges.
//      -> outputs/state/busy 0 immediately; no strobe effect until release.

Source files
------------

// File: rtl/envelope_gen_if.sv
// Sample/note bus between the sine source, melody sequencer and envelope stage.
// The DUT takes the slave side; the driver of note events and samples takes the master side.
interface envelope_gen_if #(
  parameter int N = 8
) ();
  logic         sample_en;
  logic         note_on;
  logic         note_off;
  logic [N-1:0] pos_in;
  logic [N-1:0] neg_in;
  logic [N-1:0] pos_out;
  logic [N-1:0] neg_out;
  logic         busy;
  logic [1:0]   state;

  modport master (
    output sample_en, note_on, note_off, pos_in, neg_in,
    input  pos_out, neg_out, busy, state
  );

  modport slave (
    input  sample_en, note_on, note_off, pos_in, neg_in,
    output pos_out, neg_out, busy, state
  );
endinterface

// File: rtl/envelope_gen.sv
// Attack/sustain/release amplitude envelope applied to the pos/neg half-wave samples.
// Gain steps once per sample strobe; note events move the state without touching gain.
module envelope_gen #(
  parameter int N            = 8,
  parameter int G            = 8,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 8
) (
  input  logic           clk,
  input  logic           reset,
  envelope_gen_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ATTACK  = 2'b01,
    SUSTAIN = 2'b10,
    RELEASE = 2'b11
  } state_t;

  localparam logic [G-1:0] GMAX  = {G{1'b1}};
  localparam logic [G:0]   ASTEP = (G+1)'(ATTACK_STEP);
  localparam logic [G:0]   RSTEP = (G+1)'(RELEASE_STEP);

  state_t       state_q, state_d;
  logic [G-1:0] gain_q, gain_d;
  logic [N-1:0] pos_p1, neg_p1;

  // Sum held in G+1 bits so the carry flags overflow instead of wrapping
  function automatic logic [G-1:0] sat_add(input logic [G-1:0] g);
    logic [G:0] s;
    s = {1'b0, g} + ASTEP;
    return s[G] ? GMAX : s[G-1:0];
  endfunction

  function automatic logic [G-1:0] sat_sub(input logic [G-1:0] g);
    logic [G:0] d;
    d = {1'b0, g} - RSTEP;
    return d[G] ? '0 : d[G-1:0];
  endfunction

  // Full-scale gain passes the sample through untouched rather than losing 1 LSB
  function automatic logic [N-1:0] scale(input logic [N-1:0] x, input logic [G-1:0] g);
    logic [N+G-1:0] prod;
    prod = {{G{1'b0}}, x} * {{N{1'b0}}, g};
    return (g == GMAX) ? x : prod[N+G-1:G];
  endfunction

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    if (bus.note_on) begin
      state_d = ATTACK;
    end else if (bus.note_off && (state_q == ATTACK || state_q == SUSTAIN)) begin
      state_d = RELEASE;
    end else if (bus.sample_en) begin
      case (state_q)
        ATTACK: begin
          gain_d = sat_add(gain_q);
          if (gain_d == GMAX) state_d = SUSTAIN;
        end
        SUSTAIN: gain_d = GMAX;
        RELEASE: begin
          gain_d = sat_sub(gain_q);
          if (gain_d == '0) state_d = IDLE;
        end
        default: gain_d = '0;
      endcase
    end
  end

  // Stage p1: registered scaled samples, using the gain from before this edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gain_q  <= '0;
      pos_p1  <= '0;
      neg_p1  <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      if (bus.sample_en) begin
        pos_p1 <= scale(bus.pos_in, gain_q);
        neg_p1 <= scale(bus.neg_in, gain_q);
      end
    end
  end

  assign bus.pos_out = pos_p1;
  assign bus.neg_out = neg_p1;
  assign bus.state   = state_q;
  assign bus.busy    = (state_q != IDLE);
endmodule
